// File: rtl/edge_pkg.sv
// Shared edge-code definitions for the edge detector / edge replay pair.
package edge_pkg;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2,
        EDGE_RSVD = 2'd3
    } edge_code_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DWELL = 1'b1
    } replay_state_t;

    // A transition is legal only if it actually changes the current level.
    function automatic logic is_legal_edge(input edge_code_t code, input logic level);
        return ((code == EDGE_RISE) && (level == 1'b0)) ||
               ((code == EDGE_FALL) && (level == 1'b1));
    endfunction

endpackage

// File: rtl/edge_cmd_fifo.sv
// Small synchronous FIFO for queued edge commands; wrap-bit pointers distinguish full from empty.
module edge_cmd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [1:0] push_data,
    input  logic       pop,
    output logic [1:0] pop_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [1:0]  mem_r [DEPTH];
    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    logic        do_push_s;
    logic        do_pop_s;

    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;
    assign pop_data  = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update; reset discards any queued contents.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage write; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/edge_replay.sv
// Rebuilds a level line from queued edge codes, spacing transitions by at least MIN_DWELL cycles
// and echoing each applied transition on edge_out.
module edge_replay
    import edge_pkg::*;
#(
    parameter bit DEFAULT    = 1'b0,
    parameter int MIN_DWELL  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] cmd,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       err_clr,
    output logic       level_out,
    output logic [1:0] edge_out,
    output logic       busy,
    output logic       err_sticky
);

    localparam int CNT_W = $clog2(MIN_DWELL + 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(MIN_DWELL - 1);

    replay_state_t   state_r;
    logic [CNT_W-1:0] cnt_r;

    logic       full_s;
    logic       empty_s;
    logic [1:0] head_data_s;
    edge_code_t cmd_code_s;
    edge_code_t head_code_s;
    logic       accept_s;
    logic       push_s;
    logic       rsvd_s;
    logic       pop_s;
    logic       legal_s;
    logic       redundant_s;

    edge_cmd_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_s),
        .push_data(cmd),
        .pop      (pop_s),
        .pop_data (head_data_s),
        .full     (full_s),
        .empty    (empty_s)
    );

    assign busy = ~empty_s | (state_r == ST_DWELL);

    // Accept filtering: only real transitions are queued, reserved codes flag an error.
    always_comb begin
        cmd_ready  = rst & ~full_s;
        accept_s   = cmd_valid & cmd_ready;
        cmd_code_s = edge_code_t'(cmd);
        push_s     = 1'b0;
        rsvd_s     = 1'b0;
        case (cmd_code_s)
            EDGE_RISE, EDGE_FALL: push_s = accept_s;
            EDGE_RSVD:            rsvd_s = accept_s;
            EDGE_NONE:            push_s = 1'b0;
            default:              push_s = 1'b0;
        endcase
    end

    // Pop decision: the dwell counter must have expired before the next command executes.
    always_comb begin
        head_code_s = edge_code_t'(head_data_s);
        if (state_r == ST_IDLE) begin
            pop_s = ~empty_s;
        end else begin
            pop_s = ~empty_s & (cnt_r == '0);
        end
        legal_s     = pop_s & is_legal_edge(head_code_s, level_out);
        redundant_s = pop_s & ~legal_s;
    end

    // Replay FSM with registered level, echo and sticky error.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            level_out  <= DEFAULT;
            edge_out   <= EDGE_NONE;
            err_sticky <= 1'b0;
        end else begin
            edge_out <= EDGE_NONE;
            if (legal_s) begin
                level_out <= ~level_out;
                edge_out  <= head_code_s;
                cnt_r     <= DWELL_LOAD;
                state_r   <= ST_DWELL;
            end else if (redundant_s) begin
                cnt_r   <= '0;
                state_r <= ST_IDLE;
            end else if (state_r == ST_DWELL) begin
                if (cnt_r != '0) begin
                    cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    state_r <= ST_IDLE;
                end
            end else begin
                state_r <= ST_IDLE;
            end

            // A new error takes priority over a simultaneous clear.
            if (rsvd_s | redundant_s) begin
                err_sticky <= 1'b1;
            end else if (err_clr) begin
                err_sticky <= 1'b0;
            end else begin
                err_sticky <= err_sticky;
            end
        end
    end

endmodule

// File: tb/tb_edge_replay.sv
// Directed self-checking bench for edge_replay (DEFAULT=0 main instance, DEFAULT=1 reset instance).
module tb_edge_replay;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] cmd0, cmd1;
    logic       valid0, valid1;
    logic       clr0, clr1;
    logic       ready0, ready1;
    logic       level0, level1;
    logic [1:0] edge0, edge1;
    logic       busy0, busy1;
    logic       err0, err1;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    edge_replay #(.DEFAULT(1'b0), .MIN_DWELL(4), .FIFO_DEPTH(4)) u_dut0 (
        .clk(clk), .rst(rst), .cmd(cmd0), .cmd_valid(valid0), .cmd_ready(ready0),
        .err_clr(clr0), .level_out(level0), .edge_out(edge0), .busy(busy0), .err_sticky(err0)
    );

    edge_replay #(.DEFAULT(1'b1), .MIN_DWELL(4), .FIFO_DEPTH(4)) u_dut1 (
        .clk(clk), .rst(rst), .cmd(cmd1), .cmd_valid(valid1), .cmd_ready(ready1),
        .err_clr(clr1), .level_out(level1), .edge_out(edge1), .busy(busy1), .err_sticky(err1)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] seq4 [6];
    int idx, napp, prev_cyc;
    logic acc, saw_low;

    initial begin
        rst = 1'b0; cmd0 = 2'd0; cmd1 = 2'd0; valid0 = 1'b0; valid1 = 1'b0;
        clr0 = 1'b0; clr1 = 1'b0;
        seq4[0] = 2'd2; seq4[1] = 2'd1; seq4[2] = 2'd2;
        seq4[3] = 2'd1; seq4[4] = 2'd2; seq4[5] = 2'd1;

        // Reset state
        tick(); tick();
        check("rst_level0", level0, 8'd0);
        check("rst_level1", level1, 8'd1);
        check("rst_ready0", ready0, 8'd0);
        check("rst_busy0", busy0, 8'd0);
        check("rst_edge1", edge1, 8'd0);
        rst = 1'b1;
        tick();
        check("rel_level1", level1, 8'd1);
        check("rel_edge1", edge1, 8'd0);
        check("rel_ready1", ready1, 8'd1);
        check("rel_busy1", busy1, 8'd0);
        check("rel_err1", err1, 8'd0);

        // DEFAULT=1 instance: a fall is applied one edge after acceptance
        valid1 = 1'b1; cmd1 = 2'd2;
        tick();
        valid1 = 1'b0;
        check("d1_hold", level1, 8'd1);
        tick();
        check("d1_fall_level", level1, 8'd0);
        check("d1_fall_edge", edge1, 8'd2);
        tick(); tick(); tick(); tick();

        // Back-to-back rise, fall, rise at edges 0,1,2
        valid0 = 1'b1; cmd0 = 2'd1;
        tick();
        check("t2_c0_level", level0, 8'd0);
        check("t2_c0_edge", edge0, 8'd0);
        cmd0 = 2'd2;
        tick();
        check("t2_c1_level", level0, 8'd1);
        check("t2_c1_edge", edge0, 8'd1);
        cmd0 = 2'd1;
        tick();
        valid0 = 1'b0;
        check("t2_c2_edge", edge0, 8'd0);
        for (int c = 3; c <= 14; c++) begin
            tick();
            check("t2_edge", edge0, (c == 5) ? 8'd2 : ((c == 9) ? 8'd1 : 8'd0));
            check("t2_level", level0, (c >= 5 && c < 9) ? 8'd0 : 8'd1);
            check("t2_busy", busy0, (c < 13) ? 8'd1 : 8'd0);
        end

        // Redundant command: first bring the line low
        valid0 = 1'b1; cmd0 = 2'd2;
        tick();
        valid0 = 1'b0;
        tick(); tick(); tick(); tick(); tick();
        check("t3_pre_level", level0, 8'd0);
        check("t3_pre_busy", busy0, 8'd0);
        valid0 = 1'b1; cmd0 = 2'd1;
        tick();
        tick();
        valid0 = 1'b0;
        check("t3_rise_level", level0, 8'd1);
        check("t3_rise_edge", edge0, 8'd1);
        check("t3_err_early", err0, 8'd0);
        tick(); tick(); tick();
        check("t3_err_before", err0, 8'd0);
        tick();
        check("t3_err_set", err0, 8'd1);
        check("t3_red_level", level0, 8'd1);
        check("t3_red_edge", edge0, 8'd0);
        check("t3_no_dwell", busy0, 8'd0);
        tick();
        check("t3_err_hold", err0, 8'd1);
        clr0 = 1'b1;
        tick();
        clr0 = 1'b0;
        check("t3_err_clr", err0, 8'd0);

        // Six alternating commands with cmd_valid held high
        idx = 0; napp = 0; prev_cyc = 0; saw_low = 1'b0;
        valid0 = 1'b1; cmd0 = seq4[0];
        for (int cyc = 1; cyc <= 40; cyc++) begin
            acc = valid0 & ready0;
            if (valid0 && !ready0) saw_low = 1'b1;
            tick();
            if (acc) idx++;
            if (idx >= 6) valid0 = 1'b0;
            else cmd0 = seq4[idx];
            if (edge0 != 2'd0) begin
                check("t4_code", edge0, (napp < 6) ? seq4[napp] : 8'd0);
                if (napp > 0) check("t4_gap", cyc - prev_cyc, 8'd4);
                prev_cyc = cyc;
                napp++;
            end
        end
        check("t4_accepted", idx, 8'd6);
        check("t4_applied", napp, 8'd6);
        check("t4_ready_low", saw_low, 8'd1);
        check("t4_level", level0, 8'd1);
        check("t4_busy", busy0, 8'd0);

        // Code 0 then code 3: nothing queued, error only for code 3
        valid0 = 1'b1; cmd0 = 2'd0;
        check("t5_ready", ready0, 8'd1);
        tick();
        valid0 = 1'b0;
        check("t5_c0_err", err0, 8'd0);
        check("t5_c0_busy", busy0, 8'd0);
        valid0 = 1'b1; cmd0 = 2'd3;
        tick();
        valid0 = 1'b0;
        check("t5_c3_err", err0, 8'd1);
        check("t5_c3_busy", busy0, 8'd0);
        tick();
        check("t5_level", level0, 8'd1);
        check("t5_edge", edge0, 8'd0);
        clr0 = 1'b1;
        tick();
        clr0 = 1'b0;

        // Reset two cycles into a dwell with three commands queued
        valid0 = 1'b1; cmd0 = 2'd2;
        tick();
        cmd0 = 2'd1;
        tick();
        check("t6_fall", level0, 8'd0);
        cmd0 = 2'd2;
        tick();
        cmd0 = 2'd1;
        tick();
        valid0 = 1'b0;
        check("t6_busy_pre", busy0, 8'd1);
        rst = 1'b0;
        tick();
        check("t6_level", level0, 8'd0);
        check("t6_busy", busy0, 8'd0);
        check("t6_ready", ready0, 8'd0);
        check("t6_err", err0, 8'd0);
        check("t6_level1", level1, 8'd1);
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("t6_no_edge", edge0, 8'd0);
            check("t6_level_hold", level0, 8'd0);
            check("t6_busy_hold", busy0, 8'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/edge_replay.md
Name: edge_replay

Overview:
- Transmit-side counterpart of the edge-event encoder. Accepts a stream of 2-bit edge codes and reconstructs a single-bit level line from them.
- Edge codes: 0 = no change, 1 = positive change, 2 = negative change, 3 = reserved.
- Queues commands in a small FIFO and enforces a minimum dwell time between output transitions.
- Echoes each applied transition as a one-cycle edge code, so a downstream edge detector sees a matching event stream.

Parameters:
- DEFAULT, 0, level driven on level_out after reset (0 or 1).
- MIN_DWELL, 4, minimum clock cycles between consecutive level_out transitions; legal range 1 and up.
- FIFO_DEPTH, 4, command queue depth; power of two, 2 or more.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous reset, active-low (asserted when 0).
- cmd  input  2  edge code for this command.
- cmd_valid  input  1  cmd is valid this cycle.
- cmd_ready  output  1  block can accept a command this cycle.
- err_clr  input  1  clears err_sticky.
- level_out  output  1  reconstructed level, registered.
- edge_out  output  2  registered echo of the transition applied this cycle: 0 none, 1 rise, 2 fall.
- busy  output  1  FIFO non-empty or dwell in progress.
- err_sticky  output  1  set on any illegal or redundant command.

Behaviour:
- Reset (rst=0 at a clock edge) forces:
  - level_out=DEFAULT, edge_out=0, err_sticky=0, busy=0;
  - FIFO empty, state IDLE, dwell counter 0.
  - cmd_ready=0 while rst=0. Reset mid-dwell or with commands queued discards everything.
- Handshake:
  - cmd_ready = rst & !fifo_full; a command is accepted when cmd_valid & cmd_ready.
  - No pop-through when full: a full FIFO holds cmd_ready low even if a pop occurs that cycle.
- Input filtering at accept:
  - code 0: accepted and discarded.
  - code 3: accepted and discarded; sets err_sticky.
  - codes 1 and 2: pushed into the FIFO.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head and execute it.
  - DWELL: counter decrements each cycle. When the counter is 0, pop and execute if the FIFO is non-empty, else go to IDLE. Never pop while the counter is non-zero.
- Execute a popped command:
  - Legal case (rise while level_out=0, or fall while level_out=1): at the same edge, level_out toggles, edge_out = code, counter loads MIN_DWELL-1, state goes to DWELL.
  - Redundant case (rise while high, or fall while low): command dropped, err_sticky set, level_out unchanged, edge_out=0, state goes to IDLE with no dwell.
- edge_out is non-zero for exactly one cycle per applied transition and 0 otherwise.
- Timing:
  - Consecutive applied transitions are exactly MIN_DWELL cycles apart when back-to-back commands are queued; never fewer.
  - Latency: a command accepted at edge t into an empty, IDLE block changes level_out at edge t+1 (visible in cycle t+1 onward).
- err_sticky:
  - Cleared by err_clr=1.
  - If err_clr and a new error occur in the same cycle, the set wins.
- busy = fifo_nonempty | (state==DWELL).
- FIFO pointers are log2(FIFO_DEPTH)+1 bits wide, with a wrap bit for the full/empty distinction.
- Simultaneous push and pop with the FIFO not full are both honoured; occupancy is unchanged.

Decomposition:
- Shared package edge_pkg:
  - typedef enum logic[1:0] edge_code_t {EDGE_NONE=0, EDGE_RISE=1, EDGE_FALL=2, EDGE_RSVD=3}, reused by the existing edge detector.
  - typedef enum logic {ST_IDLE, ST_DWELL} replay_state_t.
- One sub-module: edge_cmd_fifo, a synchronous FIFO (2-bit width, FIFO_DEPTH deep) with full and empty outputs and the same clk/rst.

Test Plan:
- Reset with DEFAULT=1, then release -> level_out=1, edge_out=0, cmd_ready=1, busy=0, err_sticky=0.
- DEFAULT=0, MIN_DWELL=4; send rise, fall, rise back-to-back at edges 0, 1, 2 -> level_out rises at edge 1, falls at 5, rises at 9; edge_out=1, 2, 1 in cycles 1, 5, 9, else 0; busy drops in cycle 13.
- Send rise, then rise again while high -> first applied; second dropped with no dwell; err_sticky=1 until err_clr=1, which clears it next cycle.
- Hold cmd_valid=1 with 6 legal alternating commands, FIFO_DEPTH=4, MIN_DWELL=4 -> cmd_ready low once 4 are queued; all 6 applied in order, 4 cycles apart; none lost.
- Send code 3 and code 0 -> both accepted, nothing queued, level_out unchanged; err_sticky=1 for code 3 only.
- Reset asserted two cycles into a dwell with 3 commands queued -> immediately level_out=DEFAULT, FIFO empty, busy=0; no edge_out pulses after reset.
